// File: rtl/cache_fill_fsm_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache block-fill responder:
//   - state_e      : fill FSM state encoding (IDLE / FILL)
//   - addr_t/cnt_t : 16-bit byte address and word-counter types
//   - block geometry constants (16-bit words, 8 words per 16-byte block)
//   - block_base() / word_addr() : block-aligned address helpers
// ---------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    localparam int WORD_BYTES      = 2;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int BLOCK_BYTES     = WORD_BYTES * WORDS_PER_BLOCK;
    localparam int OFFSET_BITS     = $clog2(BLOCK_BYTES);
    // Bits needed to name one word inside a block.
    localparam int IDX_BITS        = OFFSET_BITS - 1;
    // Word counters need one extra bit so they can hold the saturated value 8.
    localparam int CNT_BITS        = IDX_BITS + 1;

    typedef logic [15:0]         addr_t;
    typedef logic [CNT_BITS-1:0] cnt_t;

    // Clear the byte-offset bits of an address.
    function automatic addr_t block_base(input addr_t a);
        return {a[15:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

    // Byte address of word idx in the block at base. base has a zero offset
    // field, so splicing the index in is identical to adding it: no carry can
    // reach the tag bits and the fill never wraps into the next block.
    function automatic addr_t word_addr(input addr_t base, input logic [IDX_BITS-1:0] idx);
        return {base[15:OFFSET_BITS], idx, 1'b0};
    endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// ---------------------------------------------------------------------------
// cache_fill_fsm_if
// Miss-handling bus between the cache/memory interface (master) and the fill
// responder (slave).
//   master -> slave : miss_detected, miss_address, memory_data_valid
//   slave -> master : fsm_busy, mem_req, memory_address,
//                     write_data_array, write_tag_array, fill_address
// ---------------------------------------------------------------------------
interface cache_fill_fsm_if;
    import cache_pkg::*;

    logic  miss_detected;
    addr_t miss_address;
    logic  memory_data_valid;
    logic  fsm_busy;
    logic  mem_req;
    addr_t memory_address;
    logic  write_data_array;
    logic  write_tag_array;
    addr_t fill_address;

    modport master (
        output miss_detected, miss_address, memory_data_valid,
        input  fsm_busy, mem_req, memory_address,
               write_data_array, write_tag_array, fill_address
    );

    modport slave (
        input  miss_detected, miss_address, memory_data_valid,
        output fsm_busy, mem_req, memory_address,
               write_data_array, write_tag_array, fill_address
    );

endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// ---------------------------------------------------------------------------
// fill_counter
// Word counter for one side (issue or return) of a block fill.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   clr      : synchronous clear, has priority over inc
//   inc      : count up by one; the count saturates at WORDS_PER_BLOCK
//   cnt      : current count
// ---------------------------------------------------------------------------
module fill_counter
    import cache_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output cnt_t cnt
);

    cnt_t cnt_q;
    cnt_t cnt_d;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < cnt_t'(WORDS_PER_BLOCK))) begin
            cnt_d = cnt_q + cnt_t'(1);
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of the order blocks are evaluated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// cache_fill_fsm
// Memory-side responder for cache misses. On a sampled miss it latches the
// block base, issues WORDS_PER_BLOCK sequential word reads to pipelined main
// memory, writes each returned word into the data array, writes the tag with
// the last word, and holds fsm_busy for the whole fill.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cache_fill_fsm_if.slave
//              in : miss_detected, miss_address, memory_data_valid
//              out: fsm_busy, mem_req, memory_address,
//                   write_data_array, write_tag_array, fill_address
// Requests and returns are tracked by independent counters, so a return may
// arrive in the same cycle as a later request. Completion is decided purely by
// counting valid strobes; memory latency is never timed here.
// ---------------------------------------------------------------------------
module cache_fill_fsm
    import cache_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    cache_fill_fsm_if.slave bus
);

    state_e state_q, state_d;
    addr_t  base_q, base_d;
    cnt_t   req_cnt, rcv_cnt;

    logic   start;
    logic   req_open;
    logic   rcv_inc;

    logic   fsm_busy;
    logic   mem_req;
    addr_t  memory_address;
    logic   write_data_array;
    logic   write_tag_array;
    addr_t  fill_address;

    // Only an IDLE-state miss starts a fill; misses during FILL are ignored.
    assign start    = (state_q == IDLE) && bus.miss_detected;
    assign req_open = (state_q == FILL) && (req_cnt < cnt_t'(WORDS_PER_BLOCK));
    // Returns seen in IDLE (e.g. stragglers from a fill cut short by reset)
    // are dropped here.
    assign rcv_inc  = (state_q == FILL) && bus.memory_data_valid;

    fill_counter u_req_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .inc (req_open),
        .cnt (req_cnt)
    );

    fill_counter u_rcv_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .inc (rcv_inc),
        .cnt (rcv_cnt)
    );

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        fsm_busy         = 1'b0;
        mem_req          = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_address     = '0;

        case (state_q)
            IDLE: begin
                if (bus.miss_detected) begin
                    base_d  = block_base(bus.miss_address);
                    state_d = FILL;
                end
            end
            FILL: begin
                fsm_busy         = 1'b1;
                mem_req          = req_open;
                if (req_open) begin
                    memory_address = word_addr(base_q, req_cnt[IDX_BITS-1:0]);
                end
                write_data_array = bus.memory_data_valid;
                fill_address     = word_addr(base_q, rcv_cnt[IDX_BITS-1:0]);
                // The final word carries the tag write and ends the fill.
                if (bus.memory_data_valid && (rcv_cnt == cnt_t'(WORDS_PER_BLOCK - 1))) begin
                    write_tag_array = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    assign bus.fsm_busy         = fsm_busy;
    assign bus.mem_req          = mem_req;
    assign bus.memory_address   = memory_address;
    assign bus.write_data_array = write_data_array;
    assign bus.write_tag_array  = write_tag_array;
    assign bus.fill_address     = fill_address;

    // Memory must never return more words than one block holds.
    a_rcv_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        ((state_q == FILL) && bus.memory_data_valid) |-> (rcv_cnt < cnt_t'(WORDS_PER_BLOCK))
    );

endmodule
